uart_fifo_core: RTL and testbench

- Parametrised UART engine that succeeds the fixed 8N1 UART used under the Basys3 top.
- Contains a programmable baud/oversample tick generator, an oversampling receiver with glitch rejection and framing check, and a transmitter with a valid/ready handshake.
- Adds a first-word-fall-through RX FIFO with overrun flag and an internal loopback mode.
- Sits between the board pins (rx/tx) and user logic; the seven-segment display consumes rx_data and rx_count.

---
 rtl/uart_fifo_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: parametrised UART engine with a shared baud/oversample tick
// generator, an oversampling receiver (glitch rejection, framing check), a
// valid/ready transmitter, a first-word-fall-through RX FIFO with overrun
// flag, and an internal loopback path.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx                  serial input pin (asynchronous to clk)
//   loopback_enable     1 = receiver listens to the internal TX stream
//   tx_data/tx_valid    word to transmit, accepted when tx_ready is high
//   tx_ready            transmitter idle
//   rx_data/rx_valid    FIFO head / FIFO not empty
//   rx_ready            pop FIFO head
//   rx_count            FIFO occupancy
//   rx_overrun          pulse: received word dropped, FIFO full
//   rx_frame_err        pulse: stop bit sampled low
//   tx                  serial output pin (held idle during loopback)
//   rx_monitor          synchronised rx pin
//   tx_monitor          internal TX serial stream
module uart_fifo_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              loopback_enable,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
  output logic                              rx_overrun,
  output logic                              rx_frame_err,
  output logic                              tx,
  output logic                              rx_monitor,
  output logic                              tx_monitor
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Free-running tick generator shared by both directions.
  logic [DW-1:0] div_q;
  logic          tick;
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Synchronisers: one for the receiver input (pin or loopback), one that
  // always watches the pin so it can be observed regardless of loopback.
  logic       tx_q;
  logic [1:0] rx_sync_q, pin_sync_q;
  logic       serial_in, rx_s;
  assign serial_in = loopback_enable ? tx_q : rx;
  assign rx_s      = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      pin_sync_q <= 2'b11;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], serial_in};
      pin_sync_q <= {pin_sync_q[0], rx};
    end
  end

  // Receiver FSM
  rx_state_t             rx_state_q, rx_state_d;
  logic [TW-1:0]         rx_tcnt_q, rx_tcnt_d;
  logic [BW-1:0]         rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  push, ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    ferr       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
      end
      RX_START: if (tick) begin
        // Half a bit in: a line that is high again was only a glitch.
        if (rx_tcnt_q == OS_MID) begin
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_tcnt_d = rx_tcnt_q + 1'b1;
        end
      end
      RX_DATA: if (tick) begin
        if (rx_tcnt_q == OS_LAST) begin
          rx_tcnt_d  = '0;
          // LSB arrives first, so shift in from the top.
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_tcnt_d = rx_tcnt_q + 1'b1;
        end
      end
      RX_STOP: if (tick) begin
        if (rx_tcnt_q == OS_LAST) begin
          rx_tcnt_d = '0;
          if (rx_s) begin
            push       = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            ferr       = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_tcnt_d = rx_tcnt_q + 1'b1;
        end
      end
      // A held-low line (break) must not start a new frame.
      RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FIFO, first-word fall-through
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 overrun_q, frame_err_q;
  logic                 pop, full, do_push, drop;

  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (count_q == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overrun_q   <= drop;
      frame_err_q <= ferr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign rx_data      = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_count     = count_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;
  assign rx_monitor   = pin_sync_q[1];

  // Transmitter FSM
  tx_state_t             tx_state_q, tx_state_d;
  logic [TW-1:0]         tx_tcnt_q, tx_tcnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_tcnt_d  = '0;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_tcnt_d = tx_tcnt_q + 1'b1;
        end
      end
      TX_DATA: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_tcnt_d = tx_tcnt_q + 1'b1;
        end
      end
      TX_STOP: if (tick) begin
        if (tx_tcnt_q == OS_LAST) begin
          tx_tcnt_d  = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_tcnt_d = tx_tcnt_q + 1'b1;
        end
      end
    endcase
  end

  assign tx_ready   = (tx_state_q == TX_IDLE);
  assign tx_monitor = tx_q;
  assign tx         = loopback_enable ? 1'b1 : tx_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
`timescale 1ns/1ps
module tb_uart_fifo_core;
  localparam int DEPTH   = 4;
  localparam int BIT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n, rx, loopback_enable, tx_valid, tx_ready;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] rx_count;
  logic       rx_overrun, rx_frame_err, tx, rx_monitor, tx_monitor;

  uart_fifo_core #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .loopback_enable(loopback_enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .tx(tx), .rx_monitor(rx_monitor), .tx_monitor(tx_monitor)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int         ovr_seen = 0, ferr_seen = 0, ovr_exp = 0, ferr_exp = 0;
  bit         mon_en = 1'b0, rand_rdy = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick_n(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pulse counting and scoreboard pops on each FIFO handshake.
  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en && rst_n === 1'b1) begin
      if (rx_overrun)   ovr_seen++;
      if (rx_frame_err) ferr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          check("rx_byte", rx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_tx_idle(string name);
    int c = 0;
    while (!tx_ready && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!tx_ready) timeout_fail(name);
  endtask

  task automatic send_tx(logic [7:0] b);
    wait_tx_idle("tx_accept_wait");
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_tx_idle("tx_done_wait");
  endtask

  // Drive one frame on the rx pin; optionally pulse rx_ready for one cycle
  // at negedge index pop_at (counted from the start-bit edge).
  task automatic send_frame(logic [7:0] b, logic stop, int pop_at);
    int k;
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      k  = c / BIT_CYC;
      rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      if (pop_at >= 0) begin
        if (c == pop_at)          rx_ready = 1'b1;
        else if (c == pop_at + 1) rx_ready = 1'b0;
      end
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  initial begin
    logic [7:0] b;
    int c, tx_bad, lowc;
    rst_n = 1'b0; rx = 1'b1; loopback_enable = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    #23;
    check("rst_tx", tx, 1);
    check("rst_tx_monitor", tx_monitor, 1);
    check("rst_rx_monitor", rx_monitor, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_rx_frame_err", rx_frame_err, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick_n(4);

    // TX waveform, loopback off
    b = 8'h55;
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    c = 0;
    while (!tx_ready && c < 400) begin
      if (c % BIT_CYC == 8) check($sformatf("tx_bit%0d", c / BIT_CYC), tx, frame_bit(b, c / BIT_CYC));
      @(negedge clk);
      c++;
    end
    check("tx_ready_low_cycles", c, 10 * BIT_CYC);
    tick_n(4);

    // Loopback: pin held low to show rx_monitor ignores loopback
    loopback_enable = 1'b1;
    rx = 1'b0;
    b = 8'hA5;
    exp_q.push_back(b);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    c = 0; tx_bad = 0; lowc = 0;
    while (!rx_valid && c < 165) begin
      if (tx !== 1'b1) tx_bad++;
      if (tx_monitor === 1'b0) lowc++;
      @(negedge clk);
      c++;
    end
    if (c >= 165) timeout_fail("loopback_latency");
    check("loopback_count", rx_count, 1);
    check("loopback_tx_pin_idle_violations", tx_bad, 0);
    check("loopback_tx_monitor_low_cycles", lowc, BIT_CYC * (1 + 8 - $countones(b)));
    check("rx_monitor_follows_pin", rx_monitor, 0);
    rx_ready = 1'b1;
    tick_n(3);
    rx_ready = 1'b0;
    wait_tx_idle("loopback_tx_done");
    rx = 1'b1;
    tick_n(4);
    loopback_enable = 1'b0;
    tick_n(4);

    // External frames, framing error and break
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    tick_n(6);
    check("ext_frame_delivered", exp_q.size(), 0);
    rx_ready = 1'b0;
    ferr_exp++;
    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    tick_n(48);
    check("frame_err_pulses", ferr_seen, ferr_exp);
    check("frame_err_count", rx_count, 0);
    rx = 1'b1;
    tick_n(20);
    check("break_no_byte", rx_valid, 0);
    rx_ready = 1'b1;
    b = 8'($urandom);
    exp_q.push_back(b);
    send_frame(b, 1'b1, -1);
    tick_n(6);
    check("after_break_delivered", exp_q.size(), 0);

    // Overrun and ordering
    rx_ready = 1'b0;
    loopback_enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      else                      ovr_exp++;
      send_tx(8'(i));
    end
    tick_n(8);
    check("overrun_count_full", rx_count, DEPTH);
    check("overrun_pulses", ovr_seen, ovr_exp);
    rx_ready = 1'b1;
    tick_n(6);
    check("overrun_drained_valid", rx_valid, 0);
    check("overrun_drained_queue", exp_q.size(), 0);
    rx_ready = 1'b0;
    loopback_enable = 1'b0;
    tick_n(4);

    // Glitch rejection
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    tick_n(200);
    check("glitch_no_byte", rx_valid, 0);
    check("glitch_no_err", ferr_seen, ferr_exp);

    // Push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, -1);
    end
    tick_n(4);
    check("fill_count", rx_count, DEPTH);
    b = 8'($urandom);
    exp_q.push_back(b);
    send_frame(b, 1'b1, 154);
    tick_n(4);
    check("full_pushpop_count", rx_count, DEPTH);
    check("full_pushpop_no_overrun", ovr_seen, ovr_exp);
    rx_ready = 1'b1;
    tick_n(8);
    check("full_pushpop_drained", exp_q.size(), 0);
    rx_ready = 1'b0;

    // Reset in the middle of a TX and an RX frame, FIFO not empty
    b = 8'($urandom);
    exp_q.push_back(b);
    send_frame(b, 1'b1, -1);
    tick_n(4);
    check("pre_reset_count", rx_count, 1);
    tx_data = 8'($urandom); tx_valid = 1'b1; rx = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    tick_n(3 * BIT_CYC + 8);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_tx_monitor", tx_monitor, 1);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_monitor", rx_monitor, 1);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_count", rx_count, 0);
    @(negedge clk);
    rx = 1'b1;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(4);
    loopback_enable = 1'b1;
    rx_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_tx(8'h81);
    tick_n(8);
    check("post_reset_loopback", exp_q.size(), 0);

    // Randomised traffic over both paths with random rx_ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      if ($urandom_range(0, 1) == 1) begin
        loopback_enable = 1'b1;
        send_tx(b);
      end else begin
        loopback_enable = 1'b0;
        send_frame(b, 1'b1, -1);
      end
      tick_n(4);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    rx_ready = 1'b1;
    tick_n(12);
    check("random_drained", exp_q.size(), 0);
    check("final_overrun_pulses", ovr_seen, ovr_exp);
    check("final_frame_err_pulses", ferr_seen, ferr_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
